// File: rtl/vencode_pkg.sv
// Shared colour-subcarrier NCO definitions: quadrant bit positions and quarter-wave table helpers.
package vencode_pkg;

    // Bit positions within the 2-bit quadrant field of a lookup phase.
    localparam int unsigned QUAD_MIRROR_BIT = 0;
    localparam int unsigned QUAD_NEG_BIT    = 1;

    // pi in Q30 fixed point, used to build the table at elaboration time.
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int unsigned rom_depth(input int unsigned phase_w);
        return (32'd1 << (phase_w - 32'd2)) + 32'd1;
    endfunction

    // Table peak sits at 3/4 of full scale (0x6000 for 16-bit samples).
    function automatic int unsigned sin_peak(input int unsigned amp_w);
        return 32'd3 << (amp_w - 32'd3);
    endfunction

    // round(peak * sin(pi * i / 2^(phase_w-1))) via a Q30 Taylor series, accurate far below one LSB.
    function automatic int sin_q_entry(input int unsigned i, input int unsigned phase_w,
                                       input int unsigned peak);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_Q30 * longint'(i)) >>> (phase_w - 32'd1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((longint'(peak) * sum + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/vencode_nco_if.sv
// Control and sample bus between the subcarrier NCO and its controller / chroma modulator.
interface vencode_nco_if #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned AMP_W   = 16
);
    logic               ce;
    logic [ACC_W-1:0]   freq;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_init;
    logic               cos_inv;
    logic [AMP_W-1:0]   sinus;
    logic [AMP_W-1:0]   cosinus;
    logic               valid;

    modport master (
        output ce, freq, phase_load, phase_init, cos_inv,
        input  sinus, cosinus, valid
    );

    modport slave (
        input  ce, freq, phase_load, phase_init, cos_inv,
        output sinus, cosinus, valid
    );
endinterface

// File: rtl/vencode_nco_rom.sv
// Dual-port quarter-wave sine ROM with registered outputs; shared by the sine and cosine paths.
module vencode_nco_rom
    import vencode_pkg::*;
#(
    parameter int unsigned PHASE_W  = 8,
    parameter int unsigned AMP_W    = 16,
    parameter string       ROM_FILE = "vencode_sin_q.hex"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-2:0] addr_a,
    input  logic [PHASE_W-2:0] addr_b,
    output logic [AMP_W-1:0]   data_a,
    output logic [AMP_W-1:0]   data_b
);
    localparam int unsigned DEPTH = rom_depth(PHASE_W);

    logic [AMP_W-1:0] mem [DEPTH];

    // Contents are rebuilt from the same formula that generates ROM_FILE, so no image is needed at build time.
    if (ROM_FILE == "") begin : g_unnamed_table
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_mem
        localparam logic [AMP_W-1:0] ENTRY = AMP_W'(sin_q_entry(i, PHASE_W, sin_peak(AMP_W)));
        assign mem[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= mem[addr_a];
            data_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/vencode_nco.sv
// Colour-subcarrier NCO: phase accumulator, quadrant folding into a quarter-wave ROM, signed sin/cos out.
module vencode_nco
    import vencode_pkg::*;
#(
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned PHASE_W  = 8,
    parameter int unsigned AMP_W    = 16,
    parameter string       ROM_FILE = "vencode_sin_q.hex"
) (
    input  logic          clk,
    input  logic          rst,
    vencode_nco_if.slave  bus
);
    localparam int unsigned ADDR_W = PHASE_W - 1;
    localparam int unsigned QTR    = 2 ** (PHASE_W - 2);

    logic [ACC_W-1:0]   acc;
    logic               ce_a;
    logic [PHASE_W-1:0] phase_s_c;
    logic [PHASE_W-1:0] phase_c_c;
    logic [ADDR_W-1:0]  addr_s_stb;
    logic [ADDR_W-1:0]  addr_c_stb;
    logic               neg_s_stb;
    logic               neg_c_stb;
    logic               valid_stb;
    logic               neg_s_stc;
    logic               neg_c_stc;
    logic               valid_stc;
    logic [AMP_W-1:0]   rom_s;
    logic [AMP_W-1:0]   rom_c;

    // Quadrants 1 and 3 read the table backwards, so index 0 there lands on the peak entry.
    function automatic logic [ADDR_W-1:0] fold(input logic [PHASE_W-1:0] x);
        logic [ADDR_W-1:0] idx;
        idx = ADDR_W'(x[PHASE_W-3:0]);
        return x[PHASE_W-2+QUAD_MIRROR_BIT] ? ADDR_W'(QTR) - idx : idx;
    endfunction

    // Stage A: accumulator; a load overrides the advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            ce_a <= 1'b0;
        end else begin
            if (bus.phase_load) begin
                acc <= {bus.phase_init, {(ACC_W - PHASE_W){1'b0}}};
            end else if (bus.ce) begin
                acc <= acc + bus.freq;
            end
            ce_a <= bus.ce;
        end
    end

    always_comb begin
        phase_s_c = acc[ACC_W-1 -: PHASE_W];
        phase_c_c = phase_s_c + PHASE_W'(QTR);
    end

    // Stage B: ROM addresses and sign flags; cos_inv is tied to the phase sampled here.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_s_stb <= '0;
            addr_c_stb <= '0;
            neg_s_stb  <= 1'b0;
            neg_c_stb  <= 1'b0;
            valid_stb  <= 1'b0;
        end else begin
            addr_s_stb <= fold(phase_s_c);
            addr_c_stb <= fold(phase_c_c);
            neg_s_stb  <= phase_s_c[PHASE_W-2+QUAD_NEG_BIT];
            neg_c_stb  <= phase_c_c[PHASE_W-2+QUAD_NEG_BIT] ^ bus.cos_inv;
            valid_stb  <= ce_a;
        end
    end

    vencode_nco_rom #(
        .PHASE_W  (PHASE_W),
        .AMP_W    (AMP_W),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_a (addr_s_stb),
        .addr_b (addr_c_stb),
        .data_a (rom_s),
        .data_b (rom_c)
    );

    // Stage C flag delay alongside the ROM read, then stage D sign application.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_s_stc   <= 1'b0;
            neg_c_stc   <= 1'b0;
            valid_stc   <= 1'b0;
            bus.sinus   <= '0;
            bus.cosinus <= '0;
            bus.valid   <= 1'b0;
        end else begin
            neg_s_stc   <= neg_s_stb;
            neg_c_stc   <= neg_c_stb;
            valid_stc   <= valid_stb;
            bus.sinus   <= neg_s_stc ? -rom_s : rom_s;
            bus.cosinus <= neg_c_stc ? -rom_c : rom_c;
            bus.valid   <= valid_stc;
        end
    end

endmodule

// File: tb/tb_vencode_nco.sv
// Bench for vencode_nco: cycle scoreboard against a real-valued sine model plus table and corner sequences.
module tb_vencode_nco;

    typedef struct {
        logic [15:0] s;
        logic [15:0] c;
        logic        v;
    } exp_t;

    typedef struct {
        logic [7:0]  init;
        logic [15:0] s;
        logic [15:0] c;
    } vec_t;

    localparam real PI = 3.14159265358979323846;

    logic clk;
    logic rst;

    vencode_nco_if #(.ACC_W(32), .PHASE_W(8), .AMP_W(16)) bus ();

    vencode_nco #(
        .ACC_W    (32),
        .PHASE_W  (8),
        .AMP_W    (16),
        .ROM_FILE ("vencode_sin_q.hex")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [31:0] m_acc  = '0;
    logic        m_ce_a = 1'b0;
    logic [31:0] m_freq = '0;
    vec_t        tbl[8];
    int          cnt;

    function automatic logic [15:0] ref_sin(input logic [7:0] p);
        real a;
        int  r;
        a = 24576.0 * $sin(2.0 * PI * real'(p) / 256.0);
        r = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
        return 16'(r);
    endfunction

    function automatic exp_t model(input logic [7:0] p, input logic v, input logic inv);
        exp_t       e;
        logic [7:0] pc;
        pc  = p + 8'd64;
        e.s = ref_sin(p);
        e.c = ref_sin(pc);
        if (inv) e.c = -e.c;
        e.v = v;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare the sample that matures on this edge.
    task automatic step(input logic r, input logic c, input logic ld, input logic [7:0] init,
                        input logic inv);
        exp_t e;
        exp_t z;
        z = '{s: 16'h0, c: 16'h0, v: 1'b0};
        if (r) begin
            sb.delete();
            repeat (3) sb.push_back(z);
            m_acc  = '0;
            m_ce_a = 1'b0;
        end else begin
            sb.push_back(model(m_acc[31:24], m_ce_a, inv));
            if (ld) m_acc = {init, 24'h0};
            else if (c) m_acc = m_acc + m_freq;
            m_ce_a = c;
        end
        rst            = r;
        bus.ce         = c;
        bus.phase_load = ld;
        bus.phase_init = init;
        bus.cos_inv    = inv;
        bus.freq       = m_freq;
        @(posedge clk);
        #1;
        if (sb.size() == 3) begin
            e = sb.pop_front();
            vectors++;
            if (bus.sinus !== e.s || bus.cosinus !== e.c || bus.valid !== e.v) begin
                miscompares++;
                $display("FAIL scoreboard #%0d: sinus=%h cosinus=%h valid=%b, expected %h %h %b",
                         vectors, bus.sinus, bus.cosinus, bus.valid, e.s, e.c, e.v);
            end
        end
    endtask

    initial begin
        tbl[0] = '{init: 8'h00, s: 16'h0000, c: 16'h6000};
        tbl[1] = '{init: 8'h01, s: 16'h025b, c: 16'h5ff9};
        tbl[2] = '{init: 8'h10, s: 16'h24bd, c: 16'h58b1};
        tbl[3] = '{init: 8'h20, s: 16'h43e2, c: 16'h43e2};
        tbl[4] = '{init: 8'h40, s: 16'h6000, c: 16'h0000};
        tbl[5] = '{init: 8'h80, s: 16'h0000, c: 16'ha000};
        tbl[6] = '{init: 8'hc0, s: 16'ha000, c: 16'h0000};
        tbl[7] = '{init: 8'hff, s: 16'hfda5, c: 16'h5ff9};

        rst = 1'b1;
        bus.ce = 1'b0; bus.freq = '0; bus.phase_load = 1'b0; bus.phase_init = '0; bus.cos_inv = 1'b0;

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_sinus", bus.sinus, 16'h0000);
        check("reset_cosinus", bus.cosinus, 16'h0000);
        check("reset_valid", 16'(bus.valid), 16'h0000);

        // Release with freq=0: constant phase 0, valid once the first sample matures.
        repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("freq0_sinus", bus.sinus, 16'h0000);
        check("freq0_cosinus", bus.cosinus, 16'h6000);
        check("freq0_valid", 16'(bus.valid), 16'h0001);

        // Table of fixed phases across all quadrant boundaries.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, tbl[i].init, 1'b0);
            repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check($sformatf("tbl_sin_%02h", tbl[i].init), bus.sinus, tbl[i].s);
            check($sformatf("tbl_cos_%02h", tbl[i].init), bus.cosinus, tbl[i].c);
        end

        // Full sweep one phase step per sample, wrapping past 2*pi.
        m_freq = 32'h0100_0000;
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        repeat (300) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Load and ce together: load wins, the following sample advances from the loaded phase.
        step(1'b0, 1'b1, 1'b1, 8'h20, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("load_ce_sinus", bus.sinus, 16'h43e2);
        check("load_ce_cosinus", bus.cosinus, 16'h43e2);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Accumulator wrap from 0xFF000000 with a double step.
        step(1'b0, 1'b0, 1'b1, 8'hff, 1'b0);
        m_freq = 32'h0200_0000;
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("wrap_sinus", bus.sinus, 16'h025b);
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Single-sample cosine inversion at phase 0.
        m_freq = 32'h0100_0000;
        step(1'b0, 1'b1, 1'b1, 8'hfa, 1'b0);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, (m_acc[31:24] == 8'h00) ? 1'b1 : 1'b0);
            if (bus.valid && bus.cosinus == 16'ha000) cnt++;
        end
        check("cos_inv_count", 16'(cnt), 16'd1);

        // ce dropped for five cycles mid-sweep.
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, (i >= 4 && i < 9) ? 1'b0 : 1'b1, 1'b0, 8'h00, 1'b0);
            if (!bus.valid) cnt++;
        end
        check("ce_gap_invalid_count", 16'(cnt), 16'd5);

        // Reset mid-sweep clears everything on the next edge, then the sweep restarts from 0.
        repeat (10) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_sinus", bus.sinus, 16'h0000);
        check("midrst_cosinus", bus.cosinus, 16'h0000);
        check("midrst_valid", 16'(bus.valid), 16'h0000);
        repeat (8) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
